hazard_unit: RTL and testbench

HAZARD_UNIT -- requirements
Module: hazard_unit

---
 rtl/hazard_unit.sv | 162 ++++++++++++++++
 tb/tb_hazard_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// hazard_unit: Tuse/Tnew stall and forwarding control for a 5-stage MIPS-style pipeline.
// Defining HAZARD_STALL_CNT_EN builds a free-running count of stalled cycles on stall_cnt.
module hazard_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1_D,
  input  logic [4:0]  A2_D,
  input  logic [4:0]  A3_D,
  input  logic [1:0]  Tnew_D,
  input  logic        Tuse_RSD,
  input  logic        Tuse_RSE,
  input  logic        Tuse_RTD,
  input  logic        Tuse_RTE,
  input  logic        Tuse_RTM,
  output logic        stall,
  output logic [1:0]  FwdRSD,
  output logic [1:0]  FwdRTD,
  output logic [1:0]  FwdRSE,
  output logic [1:0]  FwdRTE,
  output logic [1:0]  FwdRTM,
  output logic [31:0] stall_cnt
);

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_M    = 2'b01;
  localparam logic [1:0] FWD_W    = 2'b10;
  localparam logic [1:0] FWD_E    = 2'b11;

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic [4:0] a3;
    logic [1:0] tnew;
  } e_rec_t;

  // M.A1 has no consumer past the E stage, so only A2/A3/Tnew travel on to M.
  typedef struct packed {
    logic [4:0] a2;
    logic [4:0] a3;
    logic [1:0] tnew;
  } m_rec_t;

  e_rec_t     e_q;
  e_rec_t     e_d;
  m_rec_t     m_q;
  m_rec_t     m_d;
  logic [4:0] w_a3_q;

  logic [1:0] tuse_rs;
  logic [1:0] tuse_rt;
  logic       stall_raw;

  function automatic logic [1:0] dec_sat(input logic [1:0] t);
    dec_sat = (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  function automatic logic must_wait(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic [4:0] a3, input logic [1:0] tnew);
    must_wait = (a3 != 5'd0) && (a3 == src) && (tnew > tuse);
  endfunction

  function automatic logic [1:0] fwd_d_sel(input logic [4:0] src,
                                           input logic [4:0] e_a3, input logic [1:0] e_tnew,
                                           input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                           input logic [4:0] w_a3);
    if (src == 5'd0)                         fwd_d_sel = FWD_NONE;
    else if (e_a3 == src && e_tnew == 2'd0)  fwd_d_sel = FWD_E;
    else if (m_a3 == src && m_tnew == 2'd0)  fwd_d_sel = FWD_M;
    else if (w_a3 == src)                    fwd_d_sel = FWD_W;
    else                                     fwd_d_sel = FWD_NONE;
  endfunction

  function automatic logic [1:0] fwd_e_sel(input logic [4:0] src,
                                           input logic [4:0] m_a3, input logic [1:0] m_tnew,
                                           input logic [4:0] w_a3);
    if (src == 5'd0)                         fwd_e_sel = FWD_NONE;
    else if (m_a3 == src && m_tnew == 2'd0)  fwd_e_sel = FWD_M;
    else if (w_a3 == src)                    fwd_e_sel = FWD_W;
    else                                     fwd_e_sel = FWD_NONE;
  endfunction

  function automatic logic [1:0] fwd_m_sel(input logic [4:0] src, input logic [4:0] w_a3);
    if (src != 5'd0 && w_a3 == src) fwd_m_sel = FWD_W;
    else                            fwd_m_sel = FWD_NONE;
  endfunction

  // Earliest stage that needs each operand; 3 means the operand is never read.
  always_comb begin
    tuse_rs = 2'd3;
    tuse_rt = 2'd3;
    if (Tuse_RSD)      tuse_rs = 2'd0;
    else if (Tuse_RSE) tuse_rs = 2'd1;
    if (Tuse_RTD)      tuse_rt = 2'd0;
    else if (Tuse_RTE) tuse_rt = 2'd1;
    else if (Tuse_RTM) tuse_rt = 2'd2;
  end

  always_comb begin
    stall_raw = must_wait(A1_D, tuse_rs, e_q.a3, e_q.tnew)
              | must_wait(A2_D, tuse_rt, e_q.a3, e_q.tnew)
              | must_wait(A1_D, tuse_rs, m_q.a3, m_q.tnew)
              | must_wait(A2_D, tuse_rt, m_q.a3, m_q.tnew);
  end

  assign stall = reset & stall_raw;

  // A stalled D instruction stays in IF/ID, so E receives a bubble instead.
  always_comb begin
    e_d = '0;
    if (!stall) begin
      e_d.a1   = A1_D;
      e_d.a2   = A2_D;
      e_d.a3   = A3_D;
      e_d.tnew = dec_sat(Tnew_D);
    end
    m_d      = '0;
    m_d.a2   = e_q.a2;
    m_d.a3   = e_q.a3;
    m_d.tnew = dec_sat(e_q.tnew);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_q    <= '0;
      m_q    <= '0;
      w_a3_q <= '0;
    end else begin
      e_q    <= e_d;
      m_q    <= m_d;
      w_a3_q <= m_q.a3;
    end
  end

  always_comb begin
    FwdRSD = FWD_NONE;
    FwdRTD = FWD_NONE;
    FwdRSE = FWD_NONE;
    FwdRTE = FWD_NONE;
    FwdRTM = FWD_NONE;
    if (reset) begin
      FwdRSD = fwd_d_sel(A1_D, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew, w_a3_q);
      FwdRTD = fwd_d_sel(A2_D, e_q.a3, e_q.tnew, m_q.a3, m_q.tnew, w_a3_q);
      FwdRSE = fwd_e_sel(e_q.a1, m_q.a3, m_q.tnew, w_a3_q);
      FwdRTE = fwd_e_sel(e_q.a2, m_q.a3, m_q.tnew, w_a3_q);
      FwdRTM = fwd_m_sel(m_q.a2, w_a3_q);
    end
  end

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     cnt_q <= '0;
    else if (stall) cnt_q <= cnt_q + 32'd1;
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: randomized and directed stimulus against an in-flight instruction model;
// expected outputs are queued by the driver and compared by a negedge monitor.
`timescale 1ns/1ps
module tb_hazard_unit;

  localparam int W = 43;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1_D, A2_D, A3_D;
  logic [1:0]  Tnew_D;
  logic        Tuse_RSD, Tuse_RSE, Tuse_RTD, Tuse_RTE, Tuse_RTM;
  logic        stall;
  logic [1:0]  FwdRSD, FwdRTD, FwdRSE, FwdRTE, FwdRTM;
  logic [31:0] stall_cnt;

  hazard_unit dut (
    .clk(clk), .reset(reset),
    .A1_D(A1_D), .A2_D(A2_D), .A3_D(A3_D), .Tnew_D(Tnew_D),
    .Tuse_RSD(Tuse_RSD), .Tuse_RSE(Tuse_RSE), .Tuse_RTD(Tuse_RTD),
    .Tuse_RTE(Tuse_RTE), .Tuse_RTM(Tuse_RTM),
    .stall(stall),
    .FwdRSD(FwdRSD), .FwdRTD(FwdRTD), .FwdRSE(FwdRSE), .FwdRTE(FwdRTE), .FwdRTM(FwdRTM),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int failures = 0;

  // In-flight instructions past D: index 0 = E, 1 = M, 2 = W; ready = cycles until result exists.
  typedef struct {
    int rs;
    int rt;
    int rd;
    int ready;
  } instr_t;

  instr_t      pipe[3];
  logic [31:0] cnt_model;
  bit          cur_stall;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void clear_model();
    for (int k = 0; k < 3; k++) begin
      pipe[k].rs = 0; pipe[k].rt = 0; pipe[k].rd = 0; pipe[k].ready = 0;
    end
    cnt_model = 32'd0;
    cur_stall = 1'b0;
  endfunction

  function automatic int tuse_of(bit d, bit e, bit m);
    if (d) return 0;
    if (e) return 1;
    if (m) return 2;
    return 3;
  endfunction

  function automatic bit must_wait(int r, int tuse);
    for (int k = 0; k < 2; k++)
      if (r != 0 && pipe[k].rd == r && pipe[k].ready > tuse) return 1'b1;
    return 1'b0;
  endfunction

  // Youngest producer whose value already exists wins; W always holds a finished value.
  function automatic logic [1:0] source_of(int r, int first);
    logic [1:0] code[3];
    code[0] = 2'b11; code[1] = 2'b01; code[2] = 2'b10;
    if (r == 0) return 2'b00;
    for (int k = first; k < 3; k++)
      if (pipe[k].rd == r && (k == 2 || pipe[k].ready == 0)) return code[k];
    return 2'b00;
  endfunction

  function automatic logic [W-1:0] predict();
    int trs, trt;
    logic s;
    logic [31:0] c;
    if (!reset) return '0;
    trs = tuse_of(Tuse_RSD, Tuse_RSE, 1'b0);
    trt = tuse_of(Tuse_RTD, Tuse_RTE, Tuse_RTM);
    s = must_wait(int'(A1_D), trs) || must_wait(int'(A2_D), trt);
`ifdef HAZARD_STALL_CNT_EN
    c = cnt_model;
`else
    c = 32'd0;
`endif
    return {s, source_of(int'(A1_D), 0), source_of(int'(A2_D), 0),
            source_of(pipe[0].rs, 1), source_of(pipe[0].rt, 1), source_of(pipe[1].rt, 2), c};
  endfunction

  function automatic void advance();
    if (!reset) begin
      clear_model();
      return;
    end
    if (cur_stall) cnt_model = cnt_model + 32'd1;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[1].ready = (pipe[0].ready > 0) ? pipe[0].ready - 1 : 0;
    if (cur_stall) begin
      pipe[0].rs = 0; pipe[0].rt = 0; pipe[0].rd = 0; pipe[0].ready = 0;
    end else begin
      pipe[0].rs = int'(A1_D); pipe[0].rt = int'(A2_D); pipe[0].rd = int'(A3_D);
      pipe[0].ready = (int'(Tnew_D) > 0) ? int'(Tnew_D) - 1 : 0;
    end
  endfunction

  task automatic drive(input int a1, input int a2, input int a3, input int tnew,
                       input bit rsd, input bit rse, input bit rtd, input bit rte, input bit rtm);
    logic [W-1:0] e;
    A1_D = a1[4:0]; A2_D = a2[4:0]; A3_D = a3[4:0]; Tnew_D = tnew[1:0];
    Tuse_RSD = rsd; Tuse_RSE = rse; Tuse_RTD = rtd; Tuse_RTE = rte; Tuse_RTM = rtm;
    #1;
    e = predict();
    cur_stall = e[W-1];
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    advance();
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      tick();
    end
  endtask

  initial begin : monitor
    logic [W-1:0] e, a;
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {stall, FwdRSD, FwdRTD, FwdRSE, FwdRTE, FwdRTM, stall_cnt};
        check($sformatf("cycle%0d", n), 64'(a), 64'(e));
        n++;
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0;
    A1_D = '0; A2_D = '0; A3_D = '0; Tnew_D = '0;
    Tuse_RSD = 0; Tuse_RSE = 0; Tuse_RTD = 0; Tuse_RTE = 0; Tuse_RTM = 0;
    clear_model();
    #2;
    check("reset_outputs", 64'({stall, FwdRSD, FwdRTD, FwdRSE, FwdRTE, FwdRTM, stall_cnt}), 64'd0);
    @(posedge clk); #1;
    nops(1);
    reset = 1'b1;
    nops(2);

    // load-use: lw $8, then addu reading $8 in E
    drive(0, 0, 8, 3, 0, 0, 0, 0, 0); tick();
    drive(8, 0, 5, 2, 0, 1, 0, 0, 0); check("lu_stall_c1", 64'(stall), 64'd1); tick();
    drive(8, 0, 5, 2, 0, 1, 0, 0, 0); check("lu_stall_c2", 64'(stall), 64'd0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); check("lu_fwdrse", 64'(FwdRSE), 64'd2); tick();
    nops(3);

    // load-branch: lw $8, then beq reading $8 in D
    drive(0, 0, 8, 3, 0, 0, 0, 0, 0); tick();
    drive(8, 0, 0, 0, 1, 0, 1, 0, 0); check("lb_stall_c1", 64'(stall), 64'd1); tick();
    drive(8, 0, 0, 0, 1, 0, 1, 0, 0); check("lb_stall_c2", 64'(stall), 64'd1); tick();
    drive(8, 0, 0, 0, 1, 0, 1, 0, 0); check("lb_stall_c3", 64'(stall), 64'd0);
    check("lb_fwdrsd", 64'(FwdRSD), 64'd2); tick();
    nops(3);

    // ALU-ALU: addu $9, then subu reading $9 as rt in E
    drive(1, 2, 9, 2, 0, 1, 0, 1, 0); tick();
    drive(3, 9, 10, 2, 0, 1, 0, 1, 0); check("aa_stall", 64'(stall), 64'd0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); check("aa_fwdrte", 64'(FwdRTE), 64'd1); tick();
    nops(3);

    // jal then jr $31
    drive(0, 0, 31, 0, 0, 0, 0, 0, 0); tick();
    drive(31, 0, 0, 0, 1, 0, 0, 0, 0); check("jal_stall", 64'(stall), 64'd0);
    check("jal_fwdrsd", 64'(FwdRSD), 64'd3); tick();
    nops(3);

    // writer of $0 followed by a reader of $0
    drive(1, 2, 0, 3, 0, 1, 0, 0, 0); tick();
    drive(0, 0, 4, 2, 1, 0, 1, 0, 0);
    check("zero_all", 64'({stall, FwdRSD, FwdRTD, FwdRSE, FwdRTE, FwdRTM}), 64'd0); tick();
    nops(3);

    // reset asserted in the middle of a load-use stall
    drive(0, 0, 8, 3, 0, 0, 0, 0, 0); tick();
    drive(8, 0, 5, 2, 0, 1, 0, 0, 0); check("rst_pre_stall", 64'(stall), 64'd1);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_stall_drop", 64'(stall), 64'd0);
    check("rst_cnt", 64'(stall_cnt), 64'd0);
    check("rst_fwd", 64'({FwdRSD, FwdRTD, FwdRSE, FwdRTE, FwdRTM}), 64'd0);
    clear_model();
    @(posedge clk); #1;
    nops(1);
    reset = 1'b1;
    drive(0, 0, 8, 3, 0, 0, 0, 0, 0); tick();
    drive(8, 0, 5, 2, 0, 1, 0, 0, 0); check("post_rst_stall", 64'(stall), 64'd1); tick();
    nops(3);

    // randomized traffic over a small register set so producers and consumers collide
    for (int i = 0; i < 600; i++) begin
      int a1, a2, a3, tn;
      reset = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      a1 = ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(0, 6);
      a2 = ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(0, 6);
      a3 = ($urandom_range(0, 15) == 0) ? 31 : $urandom_range(0, 6);
      tn = $urandom_range(0, 3);
      drive(a1, a2, a3, tn,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);
      tick();
    end
    reset = 1'b1;
    nops(3);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
